// File: rtl/mix_filter_pkg.sv
// Shared types, tap indices and arithmetic helpers for the multi-channel biquad filter.
package mix_filter_pkg;

   typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;

   localparam logic [2:0] TAP_B0 = 3'd0;
   localparam logic [2:0] TAP_B1 = 3'd1;
   localparam logic [2:0] TAP_B2 = 3'd2;
   localparam logic [2:0] TAP_A1 = 3'd3;
   localparam logic [2:0] TAP_A2 = 3'd4;

   // Three guard bits cover the sum of five full-scale products.
   function automatic int acc_width(input int data_w, input int coef_w);
      return data_w + coef_w + 3;
   endfunction

   function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int data_w);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (value > max_v) begin
         return max_v;
      end else if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

endpackage

// File: rtl/biquad_mac.sv
// Shared multiply-accumulate unit: one signed product per enabled cycle, cleared on the first tap.
module biquad_mac
   import mix_filter_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int ACC_W  = acc_width(DATA_W, COEF_W)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     en,
   input  logic                     clear,
   input  logic                     subtract,
   input  logic signed [DATA_W-1:0] operand,
   input  logic signed [COEF_W-1:0] coefficient,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [ACC_W-1:0] operand_ext;
   logic signed [ACC_W-1:0] coef_ext;
   logic signed [ACC_W-1:0] product;
   logic signed [ACC_W-1:0] term;
   logic signed [ACC_W-1:0] acc_reg;

   // Operands are widened first so the product is formed at accumulator width.
   always_comb begin
      operand_ext = {{(ACC_W-DATA_W){operand[DATA_W-1]}}, operand};
      coef_ext    = {{(ACC_W-COEF_W){coefficient[COEF_W-1]}}, coefficient};
      product     = operand_ext * coef_ext;
      term        = subtract ? -product : product;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_reg <= '0;
      end else if (en) begin
         acc_reg <= (clear ? '0 : acc_reg) + term;
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/mix_filter_biquad_mc.sv
// Direct-form-I biquad run per channel of a packed frame through one time-multiplexed MAC.
// Build option: define MIX_FILTER_SAT_EN to clamp results; otherwise results wrap.
module mix_filter_biquad_mc
   import mix_filter_pkg::*;
#(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 16,
   parameter logic signed [COEF_W-1:0] B0 = 16'sd16384,
   parameter logic signed [COEF_W-1:0] B1 = 16'sd0,
   parameter logic signed [COEF_W-1:0] B2 = 16'sd0,
   parameter logic signed [COEF_W-1:0] A1 = 16'sd0,
   parameter logic signed [COEF_W-1:0] A2 = 16'sd0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [CHANNELS*DATA_W-1:0]   audio_in,
   input  logic                         valid_in,
   output logic                         ready_out,
   input  logic [4:0]                   coef_shift,
   output logic [CHANNELS*DATA_W-1:0]   audio_out,
   output logic                         valid_out
);

   localparam int ACC_W = acc_width(DATA_W, COEF_W);
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

   state_t                      state_reg, state_next;
   logic [CH_W-1:0]             ch_reg, ch_next;
   logic [2:0]                  tap_reg, tap_next;
   logic [CHANNELS*DATA_W-1:0]  frame_reg;
   logic [4:0]                  shift_reg;
   logic [CHANNELS*DATA_W-1:0]  hold_packed;
   logic [CHANNELS*DATA_W-1:0]  audio_out_reg;
   logic                        valid_out_reg;

   logic signed [DATA_W-1:0]    x_lane   [CHANNELS];
   logic signed [DATA_W-1:0]    x1_reg   [CHANNELS];
   logic signed [DATA_W-1:0]    x2_reg   [CHANNELS];
   logic signed [DATA_W-1:0]    y1_reg   [CHANNELS];
   logic signed [DATA_W-1:0]    y2_reg   [CHANNELS];
   logic signed [DATA_W-1:0]    hold_reg [CHANNELS];

   logic signed [DATA_W-1:0]    x_cur;
   logic signed [DATA_W-1:0]    mac_operand;
   logic signed [COEF_W-1:0]    mac_coef;
   logic                        mac_sub;
   logic                        mac_en;
   logic                        mac_clear;
   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     shifted;
   logic signed [DATA_W-1:0]    y_val;

   // Channel 0 occupies the most significant lane.
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      assign x_lane[gi] = frame_reg[(CHANNELS-1-gi)*DATA_W +: DATA_W];
      assign hold_packed[(CHANNELS-1-gi)*DATA_W +: DATA_W] = hold_reg[gi];
   end

   assign x_cur = x_lane[ch_reg];

   always_comb begin
      mac_operand = x_cur;
      mac_coef    = B0;
      mac_sub     = 1'b0;
      case (tap_reg)
         TAP_B1: begin mac_operand = x1_reg[ch_reg]; mac_coef = B1; end
         TAP_B2: begin mac_operand = x2_reg[ch_reg]; mac_coef = B2; end
         TAP_A1: begin mac_operand = y1_reg[ch_reg]; mac_coef = A1; mac_sub = 1'b1; end
         TAP_A2: begin mac_operand = y2_reg[ch_reg]; mac_coef = A2; mac_sub = 1'b1; end
         default: ;
      endcase
   end

   assign mac_en    = (state_reg == MAC);
   assign mac_clear = (tap_reg == TAP_B0);

   biquad_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk         (clk),
      .reset       (reset),
      .en          (mac_en),
      .clear       (mac_clear),
      .subtract    (mac_sub),
      .operand     (mac_operand),
      .coefficient (mac_coef),
      .acc         (acc)
   );

   always_comb begin
      shifted = acc >>> shift_reg;
`ifdef MIX_FILTER_SAT_EN
      y_val = DATA_W'(saturate({{(64-ACC_W){shifted[ACC_W-1]}}, shifted}, DATA_W));
`else
      y_val = DATA_W'(shifted);
`endif
   end

   always_comb begin
      state_next = state_reg;
      ch_next    = ch_reg;
      tap_next   = tap_reg;
      case (state_reg)
         IDLE: begin
            if (valid_in) begin
               state_next = MAC;
               ch_next    = '0;
               tap_next   = TAP_B0;
            end
         end
         MAC: begin
            if (tap_reg == TAP_A2) begin
               state_next = SCALE;
            end else begin
               tap_next = tap_reg + 3'd1;
            end
         end
         SCALE: begin
            if (ch_reg == LAST_CH) begin
               state_next = OUT;
            end else begin
               state_next = MAC;
               ch_next    = ch_reg + 1'b1;
               tap_next   = TAP_B0;
            end
         end
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         ch_reg    <= '0;
         tap_reg   <= TAP_B0;
      end else begin
         state_reg <= state_next;
         ch_reg    <= ch_next;
         tap_reg   <= tap_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_reg     <= '0;
         shift_reg     <= '0;
         audio_out_reg <= '0;
         valid_out_reg <= 1'b0;
      end else begin
         valid_out_reg <= (state_reg == OUT);
         if (state_reg == IDLE && valid_in) begin
            frame_reg <= audio_in;
            shift_reg <= coef_shift;
         end
         if (state_reg == OUT) begin
            audio_out_reg <= hold_packed;
         end
      end
   end

   // History only moves once a channel's result is final, so an aborted frame leaves no trace.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            x1_reg[i]   <= '0;
            x2_reg[i]   <= '0;
            y1_reg[i]   <= '0;
            y2_reg[i]   <= '0;
            hold_reg[i] <= '0;
         end
      end else if (state_reg == SCALE) begin
         x2_reg[ch_reg]   <= x1_reg[ch_reg];
         x1_reg[ch_reg]   <= x_cur;
         y2_reg[ch_reg]   <= y1_reg[ch_reg];
         y1_reg[ch_reg]   <= y_val;
         hold_reg[ch_reg] <= y_val;
      end
   end

   assign ready_out = (state_reg == IDLE);
   assign audio_out = audio_out_reg;
   assign valid_out = valid_out_reg;

endmodule

// File: tb/tb_mix_filter_biquad_mc.sv
// Five filter instances with different coefficient sets share one stimulus stream;
// each is checked against an arithmetic biquad model.
module tb_mix_filter_biquad_mc;

   localparam int NI = 5;
   // 0 passthrough, 1 FIR, 2 IIR decay, 3 saturation, 4 general mix of all taps
   localparam logic signed [15:0] CB0 [NI] = '{16'sd16384, 16'sd8192, 16'sd16384, 16'sd32767, 16'sd12000};
   localparam logic signed [15:0] CB1 [NI] = '{16'sd0, 16'sd8192, 16'sd0, 16'sd0, -16'sd7000};
   localparam logic signed [15:0] CB2 [NI] = '{16'sd0, 16'sd8192, 16'sd0, 16'sd0, 16'sd3000};
   localparam logic signed [15:0] CA1 [NI] = '{16'sd0, 16'sd0, -16'sd8192, 16'sd0, -16'sd9000};
   localparam logic signed [15:0] CA2 [NI] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd4000};

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] audio_in;
   logic        valid_in;
   logic [4:0]  coef_shift;
   logic        rdy  [NI];
   logic        vout [NI];
   logic [31:0] aout [NI];

   int n_cmp = 0;
   int n_err = 0;
   int n_frame = 0;

   int hx1 [NI][2];
   int hx2 [NI][2];
   int hy1 [NI][2];
   int hy2 [NI][2];
   int expv [NI][2];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      mix_filter_biquad_mc #(
         .CHANNELS (2), .DATA_W (16), .COEF_W (16),
         .B0 (CB0[gi]), .B1 (CB1[gi]), .B2 (CB2[gi]), .A1 (CA1[gi]), .A2 (CA2[gi])
      ) u_dut (
         .clk        (clk),
         .reset      (reset),
         .audio_in   (audio_in),
         .valid_in   (valid_in),
         .ready_out  (rdy[gi]),
         .coef_shift (coef_shift),
         .audio_out  (aout[gi]),
         .valid_out  (vout[gi])
      );
   end

   // y = (b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) >>> sh, then clamp or wrap to 16 bits
   function automatic int model_y(int k, int x, int x1, int x2, int y1, int y2, int sh);
      longint acc;
      logic signed [15:0] w;
      acc = longint'(CB0[k]) * x + longint'(CB1[k]) * x1 + longint'(CB2[k]) * x2
          - longint'(CA1[k]) * y1 - longint'(CA2[k]) * y2;
      acc = acc >>> sh;
`ifdef MIX_FILTER_SAT_EN
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
`endif
      w = acc[15:0];
      return int'(w);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < NI; k++)
         for (int c = 0; c < 2; c++) begin
            hx1[k][c] = 0; hx2[k][c] = 0; hy1[k][c] = 0; hy2[k][c] = 0; expv[k][c] = 0;
         end
   endtask

   task automatic model_frame(input logic [31:0] f, input int sh);
      int x;
      logic signed [15:0] lane;
      for (int k = 0; k < NI; k++)
         for (int c = 0; c < 2; c++) begin
            lane = (c == 0) ? f[31:16] : f[15:0];
            x = int'(lane);
            expv[k][c] = model_y(k, x, hx1[k][c], hx2[k][c], hy1[k][c], hy2[k][c], sh);
            hx2[k][c] = hx1[k][c];
            hx1[k][c] = x;
            hy2[k][c] = hy1[k][c];
            hy1[k][c] = expv[k][c];
         end
   endtask

   function automatic int lane_of(input logic [31:0] v, input int c);
      logic signed [15:0] l;
      l = (c == 0) ? v[31:16] : v[15:0];
      return int'(l);
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      valid_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Offers one frame, updates the model, returns cycles from accept edge to valid_out.
   // Returns at the negedge where valid_out is seen (or when the bound expires).
   task automatic send_frame(input logic [31:0] f, input logic [4:0] sh, output int lat);
      int cnt;
      cnt = 0;
      while (!rdy[0] && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      audio_in = f;
      coef_shift = sh;
      valid_in = 1'b1;
      model_frame(f, int'(sh));
      @(negedge clk);
      valid_in = 1'b0;
      audio_in = $urandom;
      lat = 0;
      while (!vout[0] && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      n_frame++;
      $display("frame %0d: in=%h shift=%0d latency=%0d out[0]=%h out[4]=%h",
               n_frame, f, sh, lat, aout[0], aout[4]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      valid_in = 1'b1;
      audio_in = 32'h1234_5678;
      coef_shift = 5'd3;
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         n_cmp++;
         if (rdy[k] !== 1'b1 || vout[k] !== 1'b0 || aout[k] !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state[%0d]: ready=%b valid=%b out=%h required ready=1 valid=0 out=0",
                     k, rdy[k], vout[k], aout[k]);
         end
      end
      valid_in = 1'b0;
      reset = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_passthrough();
      int lat;
      do_reset();
      send_frame({16'd1000, 16'hF830}, 5'd14, lat);
      n_cmp++;
      if (lat != 13) begin
         n_err++;
         $display("FAIL pass_latency: got %0d cycles required 13", lat);
      end
      n_cmp++;
      if (aout[0] !== 32'h03E8_F830) begin
         n_err++;
         $display("FAIL pass_value: got %h required 03e8f830", aout[0]);
      end
      @(negedge clk);
      n_cmp++;
      if (vout[0] !== 1'b0 || rdy[0] !== 1'b1 || aout[0] !== 32'h03E8_F830) begin
         n_err++;
         $display("FAIL pass_pulse_hold: valid=%b ready=%b out=%h required valid=0 ready=1 out=03e8f830",
                  vout[0], rdy[0], aout[0]);
      end
   endtask

   task automatic test_fir();
      int lat;
      int left_exp [4] = '{500, 500, 500, 0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send_frame((i == 0) ? {16'd1000, 16'd0} : 32'h0, 5'd14, lat);
         n_cmp++;
         if (lane_of(aout[1], 0) != left_exp[i] || lane_of(aout[1], 1) != 0) begin
            n_err++;
            $display("FAIL fir_step%0d: got left=%0d right=%0d required left=%0d right=0",
                     i, lane_of(aout[1], 0), lane_of(aout[1], 1), left_exp[i]);
         end
      end
   endtask

   task automatic test_iir();
      int lat;
      int left_exp [5] = '{1000, 500, 250, 125, 62};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send_frame((i == 0) ? {16'd1000, 16'd0} : 32'h0, 5'd14, lat);
         n_cmp++;
         if (lane_of(aout[2], 0) != left_exp[i] || lane_of(aout[2], 1) != 0) begin
            n_err++;
            $display("FAIL iir_step%0d: got left=%0d right=%0d required left=%0d right=0",
                     i, lane_of(aout[2], 0), lane_of(aout[2], 1), left_exp[i]);
         end
      end
   endtask

   task automatic test_saturation();
      int lat;
      int sat_exp;
`ifdef MIX_FILTER_SAT_EN
      sat_exp = 32767;
`else
      // 32767*32767 >>> 14 = 65532, whose low 16 bits read as -4
      sat_exp = -4;
`endif
      do_reset();
      send_frame({16'd32767, 16'd32767}, 5'd14, lat);
      for (int c = 0; c < 2; c++) begin
         n_cmp++;
         if (lane_of(aout[3], c) != sat_exp) begin
            n_err++;
            $display("FAIL saturation_lane%0d: got %0d required %0d", c, lane_of(aout[3], c), sat_exp);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      logic [31:0] f;
      logic [4:0] sh;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         f = $urandom;
         if (i % 4 == 1) f = f & 32'h03FF_03FF;
         sh = 5'($urandom_range(6, 31));
         send_frame(f, sh, lat);
         n_cmp++;
         if (lat != 13) begin
            n_err++;
            $display("FAIL rand_latency%0d: got %0d cycles required 13", i, lat);
         end
         for (int k = 0; k < NI; k++)
            for (int c = 0; c < 2; c++) begin
               n_cmp++;
               if (lane_of(aout[k], c) != expv[k][c]) begin
                  n_err++;
                  $display("FAIL rand%0d_inst%0d_lane%0d: got %0d required %0d",
                           i, k, c, lane_of(aout[k], c), expv[k][c]);
               end
            end
      end
   endtask

   task automatic test_back_to_back();
      int accepts;
      int pulses;
      int last_acc;
      logic prev_v;
      accepts = 0;
      pulses = 0;
      last_acc = -1;
      prev_v = 1'b0;
      do_reset();
      coef_shift = 5'd13;
      valid_in = 1'b1;
      for (int cyc = 0; cyc < 84; cyc++) begin
         if (vout[0]) begin
            pulses++;
            n_cmp++;
            if (prev_v) begin
               n_err++;
               $display("FAIL b2b_pulse_width: valid_out high on consecutive cycles at %0d, required one cycle", cyc);
            end
            for (int k = 0; k < NI; k++)
               for (int c = 0; c < 2; c++) begin
                  n_cmp++;
                  if (lane_of(aout[k], c) != expv[k][c]) begin
                     n_err++;
                     $display("FAIL b2b_out_inst%0d_lane%0d: got %0d required %0d",
                              k, c, lane_of(aout[k], c), expv[k][c]);
                  end
               end
            $display("b2b pulse %0d at cycle %0d: out[4]=%h", pulses, cyc, aout[4]);
         end
         prev_v = vout[0];
         audio_in = $urandom;
         if (rdy[0]) begin
            if (last_acc >= 0) begin
               n_cmp++;
               if (cyc - last_acc != 14) begin
                  n_err++;
                  $display("FAIL b2b_spacing: got %0d cycles between accepts required 14", cyc - last_acc);
               end
            end
            last_acc = cyc;
            accepts++;
            model_frame(audio_in, 13);
         end
         @(negedge clk);
      end
      valid_in = 1'b0;
      n_cmp++;
      if (accepts != 6 || pulses != 5) begin
         n_err++;
         $display("FAIL b2b_counts: got accepts=%0d pulses=%0d required accepts=6 pulses=5", accepts, pulses);
      end
   endtask

   task automatic test_reset_mid_mac();
      int lat;
      int seen;
      int left_exp [3] = '{1000, 500, 250};
      do_reset();
      coef_shift = 5'd14;
      audio_in = {16'sd30000, -16'sd30000};
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rdy[0] !== 1'b1 || vout[0] !== 1'b0 || aout[2] !== 32'h0) begin
         n_err++;
         $display("FAIL midreset_state: ready=%b valid=%b out=%h required ready=1 valid=0 out=0",
                  rdy[0], vout[0], aout[2]);
      end
      reset = 1'b0;
      model_reset();
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (vout[0]) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL midreset_no_valid: got %0d pulses required 0", seen);
      end
      for (int i = 0; i < 3; i++) begin
         send_frame((i == 0) ? {16'd1000, 16'd0} : 32'h0, 5'd14, lat);
         n_cmp++;
         if (lane_of(aout[2], 0) != left_exp[i] || lane_of(aout[2], 1) != 0) begin
            n_err++;
            $display("FAIL midreset_iir%0d: got left=%0d right=%0d required left=%0d right=0",
                     i, lane_of(aout[2], 0), lane_of(aout[2], 1), left_exp[i]);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      valid_in = 1'b0;
      audio_in = '0;
      coef_shift = '0;
      model_reset();
      test_reset();
      test_passthrough();
      test_fir();
      test_iir();
      test_saturation();
      test_random();
      test_back_to_back();
      test_reset_mid_mac();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
